card_dealer: RTL and testbench

Generalised successor to the RNG path behind the PS/2 "deal" key. It draws cards without replacement from a parametrised shoe of NUM_DECKS x 52 cards, using a free-running LFSR plus a used-card bitmap. Each dealt card is assigned to one of NUM_HANDS hands, and the block keeps a blackjack score per hand. It sits between PS2_Controller (key pulses) and the game FSM / HEX display drivers.

---
 rtl/card_pkg.sv | 49 ++++
 rtl/card_lfsr.sv | 29 ++
 rtl/card_dealer.sv | 199 +++++++++++++++++++
 tb/tb_card_dealer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared constants, FSM state type and card helpers for the card dealer.
// Imported by card_dealer and card_lfsr.
package card_pkg;

    localparam int RANKS_PER_SUIT = 13;
    localparam int SUITS          = 4;
    localparam int CARDS_PER_DECK = 52;
    localparam int BJ_LIMIT       = 21;
    localparam int FACE_VALUE     = 10;
    localparam int ACE_BONUS      = 10;
    localparam int SCORE_W        = 6;
    localparam int HARD_W         = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROBE   = 2'd1,
        ST_DELIVER = 2'd2
    } deal_state_e;

    // Blackjack value of a rank in 1..13 (ace counts 1 here; the soft bonus is applied per hand).
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        if (rank >= 4'(FACE_VALUE)) return 4'(FACE_VALUE);
        return rank;
    endfunction

    // Right-shifting Galois feedback masks for maximal-length sequences.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0E08;
            13:      return 32'h0000_1C80;
            14:      return 32'h0000_3802;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_B400;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0007_2000;
            20:      return 32'h0009_0000;
            24:      return 32'h00E1_0000;
            32:      return 32'hA300_0000;
            default: return 32'h0000_B400;
        endcase
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running Galois LFSR; the full state is exported so other blocks can
// derive their own random fields from it.
module card_lfsr
    import card_pkg::*;
#(
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(16'hACE1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [LFSR_WIDTH-1:0] state_o
);

    localparam logic [LFSR_WIDTH-1:0] TAPS = LFSR_WIDTH'(lfsr_taps(LFSR_WIDTH));

    logic [LFSR_WIDTH-1:0] state_q;
    logic [LFSR_WIDTH-1:0] state_d;

    // The feedback mask has its top bit set, so a non-zero seed never decays to zero.
    assign state_d = {1'b0, state_q[LFSR_WIDTH-1:1]} ^ (state_q[0] ? TAPS : '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= SEED;
        else       state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/card_dealer.sv
// Draws cards without replacement from a NUM_DECKS shoe (LFSR candidate plus
// linear probe over a used-card bitmap) and keeps a blackjack score per hand.
module card_dealer
    import card_pkg::*;
#(
    parameter int                    NUM_DECKS  = 1,
    parameter int                    NUM_HANDS  = 2,
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(16'hACE1),
    localparam int HW    = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
    localparam int TOTAL = NUM_DECKS * CARDS_PER_DECK,
    localparam int CW    = $clog2(TOTAL + 1)
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         deal_req,
    input  logic [HW-1:0]                hand_sel,
    input  logic                         shuffle_req,
    output logic                         ready,
    output logic                         card_valid,
    output logic [3:0]                   card_rank,
    output logic [1:0]                   card_suit,
    output logic [HW-1:0]                card_hand,
    output logic                         deal_err,
    output logic [CW-1:0]                cards_left,
    output logic [NUM_HANDS*SCORE_W-1:0] hand_score,
    output logic [NUM_HANDS-1:0]         hand_bust,
    output deal_state_e                  dbg_state_o,
    output logic [LFSR_WIDTH-1:0]        dbg_lfsr_o
);

    localparam int DW  = $clog2(NUM_DECKS);
    localparam int DRW = (DW > 0) ? DW : 1;
    localparam int IW  = $clog2(TOTAL);

    logic [LFSR_WIDTH-1:0] lfsr;

    card_lfsr #(
        .LFSR_WIDTH(LFSR_WIDTH),
        .SEED      (SEED)
    ) u_lfsr (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .state_o(lfsr)
    );

    deal_state_e       state_q;
    logic [TOTAL-1:0]  used_q;
    logic [CW-1:0]     left_q;
    logic [3:0]        r_q;
    logic [1:0]        s_q;
    logic [DRW-1:0]    d_q;
    logic [HW-1:0]     tgt_q;
    logic              pend_q;
    logic              ready_q;
    logic              valid_q;
    logic              err_q;
    logic [3:0]        rank_q;
    logic [1:0]        suit_q;
    logic [HW-1:0]     hand_q;
    logic [HARD_W-1:0] hard_q [NUM_HANDS];
    logic [NUM_HANDS-1:0] ace_q;

    logic [3:0]        ld_r;
    logic [1:0]        ld_s;
    logic [DRW-1:0]    ld_d;
    logic [3:0]        r_d;
    logic [1:0]        s_d;
    logic [DRW-1:0]    d_d;
    logic [IW-1:0]     probe_idx;
    logic              probe_hit;
    logic [7:0]        hard_sum;
    logic [HARD_W-1:0] hard_nx;

    // Initial candidate straight from the LFSR; rank folds 13..15 back onto 0..2.
    always_comb begin
        ld_r = lfsr[3:0];
        if (ld_r >= 4'(RANKS_PER_SUIT)) ld_r = ld_r - 4'(RANKS_PER_SUIT);
        ld_s = lfsr[5:4];
    end

    if (DW > 0) begin : g_deck
        assign ld_d = lfsr[6 +: DRW];
    end else begin : g_one_deck
        assign ld_d = '0;
    end

    // Probe step: rank carries into suit, suit carries into deck, deck wraps.
    always_comb begin
        r_d = r_q + 4'd1;
        s_d = s_q;
        d_d = d_q;
        if (r_q == 4'(RANKS_PER_SUIT - 1)) begin
            r_d = 4'd0;
            s_d = s_q + 2'd1;
            if (s_q == 2'(SUITS - 1)) d_d = (d_q == DRW'(NUM_DECKS - 1)) ? '0 : d_q + 1'b1;
        end
    end

    assign probe_idx = IW'(d_q) * IW'(CARDS_PER_DECK) + IW'(s_q) * IW'(RANKS_PER_SUIT) + IW'(r_q);
    assign probe_hit = used_q[probe_idx];

    assign hard_sum = {1'b0, hard_q[tgt_q]} + {4'b0, card_value(r_q + 4'd1)};
    assign hard_nx  = (hard_sum > 8'd127) ? 7'd127 : hard_sum[6:0];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            used_q  <= '0;
            left_q  <= CW'(TOTAL);
            r_q     <= '0;
            s_q     <= '0;
            d_q     <= '0;
            tgt_q   <= '0;
            pend_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rank_q  <= '0;
            suit_q  <= '0;
            hand_q  <= '0;
            ace_q   <= '0;
            for (int h = 0; h < NUM_HANDS; h++) hard_q[h] <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (shuffle_req || pend_q) begin
                        used_q <= '0;
                        left_q <= CW'(TOTAL);
                        ace_q  <= '0;
                        pend_q <= 1'b0;
                        for (int h = 0; h < NUM_HANDS; h++) hard_q[h] <= '0;
                    end else if (deal_req && left_q == '0) begin
                        err_q <= 1'b1;
                    end else if (deal_req) begin
                        tgt_q   <= hand_sel;
                        r_q     <= ld_r;
                        s_q     <= ld_s;
                        d_q     <= ld_d;
                        ready_q <= 1'b0;
                        state_q <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    if (shuffle_req) pend_q <= 1'b1;
                    if (probe_hit) begin
                        r_q <= r_d;
                        s_q <= s_d;
                        d_q <= d_d;
                    end else begin
                        used_q[probe_idx] <= 1'b1;
                        left_q            <= left_q - CW'(1);
                        rank_q            <= r_q + 4'd1;
                        suit_q            <= s_q;
                        hand_q            <= tgt_q;
                        valid_q           <= 1'b1;
                        hard_q[tgt_q]     <= hard_nx;
                        if (r_q == 4'd0) ace_q[tgt_q] <= 1'b1;
                        state_q           <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (shuffle_req) pend_q <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A soft ace counts 11 only while that keeps the hand at or below 21.
    for (genvar h = 0; h < NUM_HANDS; h++) begin : g_score
        logic [HARD_W-1:0]  hv;
        logic [SCORE_W-1:0] sc;
        assign hv = hard_q[h];
        assign sc = (ace_q[h] && hv <= 7'd11) ? SCORE_W'(hv + 7'(ACE_BONUS))
                  : (hv > 7'd63)              ? 6'd63
                  :                             hv[SCORE_W-1:0];
        assign hand_score[h*SCORE_W +: SCORE_W] = sc;
        assign hand_bust[h]                     = sc > 6'(BJ_LIMIT);
    end

    assign ready       = ready_q;
    assign card_valid  = valid_q;
    assign card_rank   = rank_q;
    assign card_suit   = suit_q;
    assign card_hand   = hand_q;
    assign deal_err    = err_q;
    assign cards_left  = left_q;
    assign dbg_state_o = state_q;
    assign dbg_lfsr_o  = lfsr;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: a shoe/score model predicts every card,
// its latency and each hand's score from the LFSR sequence and the dealing rules.
module tb_card_dealer;
    import card_pkg::*;

    localparam int          ND    = 1;
    localparam int          NH    = 2;
    localparam int          HW    = 1;
    localparam int          TOTAL = 52;
    localparam int          CW    = 6;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic           CLOCK_50 = 1'b0;
    logic           reset;
    logic           deal_req;
    logic [HW-1:0]  hand_sel;
    logic           shuffle_req;
    logic           ready;
    logic           card_valid;
    logic [3:0]     card_rank;
    logic [1:0]     card_suit;
    logic [HW-1:0]  card_hand;
    logic           deal_err;
    logic [CW-1:0]  cards_left;
    logic [NH*6-1:0] hand_score;
    logic [NH-1:0]  hand_bust;
    deal_state_e    dbg_state;
    logic [15:0]    dbg_lfsr;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;

    card_dealer #(.NUM_DECKS(ND), .NUM_HANDS(NH), .LFSR_WIDTH(16), .SEED(SEED)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .deal_req   (deal_req),
        .hand_sel   (hand_sel),
        .shuffle_req(shuffle_req),
        .ready      (ready),
        .card_valid (card_valid),
        .card_rank  (card_rank),
        .card_suit  (card_suit),
        .card_hand  (card_hand),
        .deal_err   (deal_err),
        .cards_left (cards_left),
        .hand_score (hand_score),
        .hand_bust  (hand_bust),
        .dbg_state_o(dbg_state),
        .dbg_lfsr_o (dbg_lfsr)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr;
    bit          m_used [TOTAL];
    int          m_left;
    int          m_hard [NH];
    bit          m_ace  [NH];

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    always @(posedge CLOCK_50) if (card_valid === 1'b1) vcnt <= vcnt + 1;

    task automatic model_clear();
        for (int i = 0; i < TOTAL; i++) m_used[i] = 1'b0;
        m_left = TOTAL;
        for (int h = 0; h < NH; h++) begin
            m_hard[h] = 0;
            m_ace[h]  = 1'b0;
        end
    endtask

    function automatic int m_score(input int h);
        if (m_ace[h] && m_hard[h] <= 11) return m_hard[h] + 10;
        return (m_hard[h] > 63) ? 63 : m_hard[h];
    endfunction

    // Card index = deck*52 + suit*13 + rank; the probe walks forward linearly.
    function automatic void predict(input logic [15:0] l, output int idx, output int coll);
        int deck;
        deck = (ND > 1) ? (int'(l >> 6) % ND) : 0;
        idx  = (int'(l[3:0]) % 13) + 13 * int'(l[5:4]) + 52 * deck;
        coll = 0;
        for (int k = 0; k < TOTAL && m_used[idx]; k++) begin
            idx  = (idx + 1) % TOTAL;
            coll = coll + 1;
        end
    endfunction

    task automatic wait_ready();
        for (int w = 0; w < 100 && ready !== 1'b1; w++) @(negedge CLOCK_50);
    endtask

    // Issues one deal_req at a negedge and checks the result against the model.
    task automatic deal(input int hand);
        int idx, coll, lat, val, didx;
        wait_ready();
        predict(m_lfsr, idx, coll);
        hand_sel = HW'(hand);
        deal_req = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        deal_req = 1'b0;
        if (m_left == 0) begin
            checks++;
            if (deal_err !== 1'b1 || card_valid !== 1'b0 || ready !== 1'b1) begin
                errors++;
                $display("FAIL empty_deal: err=%b valid=%b ready=%b, need 1 0 1", deal_err, card_valid, ready);
            end
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            checks++;
            if (deal_err !== 1'b0 || card_valid !== 1'b0 || ready !== 1'b1) begin
                errors++;
                $display("FAIL empty_deal_after: err=%b valid=%b ready=%b, need 0 0 1", deal_err, card_valid, ready);
            end
            return;
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_drop: ready=%b, need 0", ready);
        end
        lat = 1;
        while (card_valid !== 1'b1 && lat < TOTAL + 10) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            lat++;
        end
        checks++;
        if (card_valid !== 1'b1) begin
            errors++;
            $display("FAIL deal_timeout: no card_valid after %0d cycles", lat);
            return;
        end
        checks++;
        if (lat != 2 + coll) begin
            errors++;
            $display("FAIL latency: got %0d cycles, need %0d", lat, 2 + coll);
        end
        checks++;
        if (card_rank !== 4'(idx % 13 + 1) || card_suit !== 2'((idx / 13) % 4) || card_hand !== HW'(hand)) begin
            errors++;
            $display("FAIL card: got r=%0d s=%0d h=%0d, need r=%0d s=%0d h=%0d",
                     card_rank, card_suit, card_hand, idx % 13 + 1, (idx / 13) % 4, hand);
        end
        didx = (int'(card_rank) - 1) + 13 * int'(card_suit);
        checks++;
        if (didx < 0 || didx >= TOTAL || m_used[didx]) begin
            errors++;
            $display("FAIL unique: card r=%0d s=%0d already dealt or out of range", card_rank, card_suit);
        end
        m_used[idx] = 1'b1;
        m_left      = m_left - 1;
        val         = (idx % 13 + 1 >= 10) ? 10 : idx % 13 + 1;
        m_hard[hand] = (m_hard[hand] + val > 127) ? 127 : m_hard[hand] + val;
        if (idx % 13 == 0) m_ace[hand] = 1'b1;
        checks++;
        if (cards_left !== CW'(m_left)) begin
            errors++;
            $display("FAIL cards_left: got %0d, need %0d", cards_left, m_left);
        end
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++;
        if (card_valid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL deliver_end: valid=%b ready=%b, need 0 1", card_valid, ready);
        end
        checks++;
        if (hand_score[hand*6 +: 6] !== 6'(m_score(hand)) || hand_bust[hand] !== (m_score(hand) > 21)) begin
            errors++;
            $display("FAIL score: hand %0d got %0d bust %b, need %0d bust %b",
                     hand, hand_score[hand*6 +: 6], hand_bust[hand], m_score(hand), m_score(hand) > 21);
        end
    endtask

    task automatic pulse_shuffle();
        shuffle_req = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        shuffle_req = 1'b0;
        model_clear();
    endtask

    task automatic check_fresh(input string name);
        checks++;
        if (cards_left !== CW'(TOTAL) || hand_score !== '0 || hand_bust !== '0) begin
            errors++;
            $display("FAIL %s: left=%0d scores=%h bust=%b, need 52 0 0", name, cards_left, hand_score, hand_bust);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; deal_req = 1'b0; shuffle_req = 1'b0; hand_sel = '0;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        model_clear();
        checks++;
        if (ready !== 1'b1 || card_valid !== 1'b0 || deal_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b valid=%b err=%b, need 1 0 0", ready, card_valid, deal_err);
        end
        check_fresh("reset_shoe");
        checks++;
        if (card_rank !== 4'd0 || card_suit !== 2'd0 || card_hand !== '0) begin
            errors++;
            $display("FAIL reset_card: r=%0d s=%0d h=%0d, need 0 0 0", card_rank, card_suit, card_hand);
        end
        checks++;
        if (dbg_lfsr !== m_lfsr) begin
            errors++;
            $display("FAIL reset_lfsr: got %h, need %h", dbg_lfsr, m_lfsr);
        end
    endtask

    task automatic test_exhaust();
        int v0;
        v0 = vcnt;
        for (int i = 0; i < TOTAL; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
            deal($urandom_range(0, NH - 1));
        end
        checks++;
        if (cards_left !== '0 || vcnt - v0 != TOTAL) begin
            errors++;
            $display("FAIL exhaust: left=%0d pulses=%0d, need 0 %0d", cards_left, vcnt - v0, TOTAL);
        end
        v0 = vcnt;
        deal(0);
        checks++;
        if (vcnt != v0) begin
            errors++;
            $display("FAIL empty_no_valid: %0d card_valid pulses, need 0", vcnt - v0);
        end
    endtask

    task automatic test_shuffle();
        pulse_shuffle();
        check_fresh("shuffle");
    endtask

    task automatic deal_rank(input int hand, input int want);
        int idx, coll, w;
        w = 0;
        predict(m_lfsr, idx, coll);
        while (idx % 13 + 1 != want && w < 1000) begin
            @(negedge CLOCK_50);
            w++;
            predict(m_lfsr, idx, coll);
        end
        checks++;
        if (w >= 1000) begin
            errors++;
            $display("FAIL seek_rank: rank %0d not reachable in %0d cycles", want, w);
        end
        deal(hand);
    endtask

    task automatic test_ace_king();
        deal_rank(1, 1);
        deal_rank(1, 13);
        checks++;
        if (hand_score[11:6] !== 6'd21 || hand_bust[1] !== 1'b0 || hand_score[5:0] !== 6'd0) begin
            errors++;
            $display("FAIL ace_king: h1=%0d bust=%b h0=%0d, need 21 0 0", hand_score[11:6], hand_bust[1], hand_score[5:0]);
        end
        deal_rank(1, 5);
        checks++;
        if (hand_score[11:6] !== 6'd16 || hand_bust[1] !== 1'b0) begin
            errors++;
            $display("FAIL ace_king_five: h1=%0d bust=%b, need 16 0", hand_score[11:6], hand_bust[1]);
        end
        deal_rank(1, 13);
        checks++;
        if (hand_score[11:6] !== 6'd26 || hand_bust[1] !== 1'b1) begin
            errors++;
            $display("FAIL bust: h1=%0d bust=%b, need 26 1", hand_score[11:6], hand_bust[1]);
        end
    endtask

    task automatic test_deferred_shuffle();
        int idx, coll, lat;
        for (int i = 0; i < 3; i++) deal($urandom_range(0, NH - 1));
        wait_ready();
        predict(m_lfsr, idx, coll);
        hand_sel = '0;
        deal_req = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        deal_req    = 1'b0;
        shuffle_req = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        shuffle_req = 1'b0;
        lat = 2;
        while (card_valid !== 1'b1 && lat < TOTAL + 10) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            lat++;
        end
        checks++;
        if (card_valid !== 1'b1 || card_rank !== 4'(idx % 13 + 1) || card_suit !== 2'((idx / 13) % 4)) begin
            errors++;
            $display("FAIL deferred_card: valid=%b r=%0d s=%0d, need 1 r=%0d s=%0d",
                     card_valid, card_rank, card_suit, idx % 13 + 1, (idx / 13) % 4);
        end
        checks++;
        if (cards_left !== CW'(m_left - 1)) begin
            errors++;
            $display("FAIL deferred_left: got %0d, need %0d", cards_left, m_left - 1);
        end
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++;
        if (cards_left !== CW'(m_left - 1) || ready !== 1'b1) begin
            errors++;
            $display("FAIL deferred_hold: left=%0d ready=%b, need %0d 1", cards_left, ready, m_left - 1);
        end
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        model_clear();
        check_fresh("deferred_apply");
    endtask

    task automatic test_last_card();
        int last;
        for (int i = 0; i < TOTAL - 1; i++) deal($urandom_range(0, NH - 1));
        last = -1;
        for (int j = 0; j < TOTAL; j++) if (!m_used[j]) last = j;
        deal(0);
        checks++;
        if (card_rank !== 4'(last % 13 + 1) || card_suit !== 2'(last / 13) || cards_left !== '0) begin
            errors++;
            $display("FAIL last_card: r=%0d s=%0d left=%0d, need r=%0d s=%0d left=0",
                     card_rank, card_suit, cards_left, last % 13 + 1, last / 13);
        end
        pulse_shuffle();
    endtask

    task automatic test_reset_mid_probe();
        int v0;
        bit seen;
        deal(0);
        deal(1);
        wait_ready();
        deal_req = 1'b1;
        hand_sel = '0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        deal_req = 1'b0;
        v0 = vcnt;
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        model_clear();
        seen = (card_valid === 1'b1);
        repeat (4) begin
            @(negedge CLOCK_50);
            if (card_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || vcnt != v0 || ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_probe: valid_seen=%b ready=%b state=%0d, need 0 1 0", seen, ready, dbg_state);
        end
        check_fresh("reset_probe_shoe");
    endtask

    task automatic test_deal_shuffle_same();
        bit seen;
        deal(1);
        wait_ready();
        deal_req    = 1'b1;
        shuffle_req = 1'b1;
        hand_sel    = '0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        deal_req    = 1'b0;
        shuffle_req = 1'b0;
        model_clear();
        seen = 1'b0;
        repeat (4) begin
            if (card_valid === 1'b1 || ready !== 1'b1) seen = 1'b1;
            @(negedge CLOCK_50);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL deal_and_shuffle: card_valid or ready drop seen, need neither");
        end
        check_fresh("deal_and_shuffle_shoe");
    endtask

    initial begin
        test_reset();
        test_exhaust();
        test_shuffle();
        test_ace_king();
        test_deferred_shuffle();
        test_last_card();
        test_reset_mid_probe();
        test_deal_shuffle_same();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
